// File: rtl/seq_code_lock.sv
// Serial code-lock controller: collects CODE_LEN bits MSB-first, unlocks on a match, alarms after MAX_FAIL misses.
// Optional build macro LOCK_TIMEOUT_EN adds an idle timeout that aborts a stalled entry as a failure.
module seq_code_lock #(
    parameter int                  CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  OPEN_CYCLES = 8,
    parameter int                  TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       MR,
    input  logic       bit_vld,
    input  logic       bit_in,
    input  logic       clr,
    output logic       unlock,
    output logic       alarm,
    output logic       busy,
    output logic [1:0] fail_cnt,
    output logic [3:0] bit_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTER = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_OPEN  = 3'd3;
    localparam logic [2:0] S_ALARM = 3'd4;

    localparam int         OT_W      = $clog2(OPEN_CYCLES + 1);
    localparam logic [OT_W-1:0] OPEN_LAST = OT_W'(OPEN_CYCLES - 1);
    localparam logic [3:0] BIT_LAST  = 4'(CODE_LEN - 1);
    localparam logic [1:0] FAIL_MAX  = 2'(MAX_FAIL);

    generate
        if (CODE_LEN < 2 || CODE_LEN > 8 || MAX_FAIL < 1 || MAX_FAIL > 3 ||
            OPEN_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
            $error("seq_code_lock: parameter out of range");
        end
    endgenerate

    logic [2:0]          state;
    logic [CODE_LEN-1:0] shreg;
    logic [OT_W-1:0]     open_tmr;
    logic [CODE_LEN-1:0] shreg_shifted;
    logic [1:0]          fail_next;
    logic [2:0]          fail_state;

`ifdef LOCK_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    // Saturating failure count and where a miss leads, shared by CHECK and the timeout abort.
    always_comb begin
        shreg_shifted = {shreg[CODE_LEN-2:0], bit_in};
        fail_next     = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 2'd1;
        fail_state    = (fail_next == FAIL_MAX) ? S_ALARM : S_IDLE;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (MR) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            fail_cnt <= '0;
            open_tmr <= '0;
`ifdef LOCK_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // clr on the same edge as a strobe drops the bit.
                    if (bit_vld && !clr) begin
                        shreg   <= shreg_shifted;
                        bit_cnt <= 4'd1;
                        state   <= S_ENTER;
`ifdef LOCK_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                S_ENTER: begin
                    if (clr) begin
                        state   <= S_IDLE;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end else if (bit_vld) begin
                        shreg   <= shreg_shifted;
                        bit_cnt <= bit_cnt + 4'd1;
`ifdef LOCK_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_CHECK;
                        end
                    end
`ifdef LOCK_TIMEOUT_EN
                    else if (idle_cnt == TO_LAST) begin
                        state    <= fail_state;
                        fail_cnt <= fail_next;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                S_CHECK: begin
                    bit_cnt <= '0;
                    if (shreg == CODE) begin
                        state    <= S_OPEN;
                        fail_cnt <= '0;
                        open_tmr <= '0;
                    end else begin
                        state    <= fail_state;
                        fail_cnt <= fail_next;
                    end
                end
                S_OPEN: begin
                    if (clr || open_tmr == OPEN_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        open_tmr <= open_tmr + 1'b1;
                    end
                end
                S_ALARM: begin
                    if (clr) begin
                        state    <= S_IDLE;
                        fail_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign unlock = (state == S_OPEN);
    assign alarm  = (state == S_ALARM);
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_seq_code_lock.sv
// Table-driven bench for seq_code_lock with default parameters; timeout expectations follow LOCK_TIMEOUT_EN.
module tb_seq_code_lock;

    typedef struct {
        logic       mr;
        logic       vld;
        logic       b;
        logic       clr;
        logic [8:0] exp;   // {unlock, alarm, busy, fail_cnt[1:0], bit_cnt[3:0]}
    } vec_t;

`ifdef LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       MR = 1'b1;
    logic       bit_vld = 1'b0;
    logic       bit_in = 1'b0;
    logic       clr = 1'b0;
    logic       unlock;
    logic       alarm;
    logic       busy;
    logic [1:0] fail_cnt;
    logic [3:0] bit_cnt;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vec_q[$];

    seq_code_lock dut (
        .clk      (clk),
        .MR       (MR),
        .bit_vld  (bit_vld),
        .bit_in   (bit_in),
        .clr      (clr),
        .unlock   (unlock),
        .alarm    (alarm),
        .busy     (busy),
        .fail_cnt (fail_cnt),
        .bit_cnt  (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic mr, input logic vld, input logic b, input logic c,
                       input logic unl, input logic alm, input logic bsy,
                       input logic [1:0] fc, input logic [3:0] bc);
        vec_t v;
        v.mr  = mr;
        v.vld = vld;
        v.b   = b;
        v.clr = c;
        v.exp = {unl, alm, bsy, fc, bc};
        vec_q.push_back(v);
    endtask

    // Four strobes MSB-first; bit_cnt climbs 1..4 while fail_cnt holds.
    task automatic add_entry(input logic [3:0] code, input logic [1:0] fc);
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 1'b1, code[3-i], 1'b0, 1'b0, 1'b0, 1'b1, fc, 4'(i + 1));
        end
    endtask

    task automatic add_idle(input int n, input logic unl, input logic alm, input logic bsy,
                            input logic [1:0] fc, input logic [3:0] bc);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 1'b0, 1'b0, 1'b0, unl, alm, bsy, fc, bc);
        end
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got {unl,alm,busy,fc,bc}=%b want %b", name, act, exp);
        end
    endtask

    task automatic drive_check(input logic mr, input logic vld, input logic b, input logic c,
                               input logic [8:0] exp, input string name);
        @(negedge clk);
        MR      = mr;
        bit_vld = vld;
        bit_in  = b;
        clr     = c;
        @(posedge clk);
        #1;
        check(name, {unlock, alarm, busy, fail_cnt, bit_cnt}, exp);
    endtask

    initial begin
        // Reset, including a strobe that must be ignored under MR.
        add(1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        add(1, 1, 1, 0, 0, 0, 0, 2'd0, 4'd0);

        // 1: correct code, strobe during CHECK ignored, 8-cycle unlock.
        add_entry(4'b1011, 2'd0);
        add(0, 1, 0, 0, 1, 0, 1, 2'd0, 4'd0);
        add_idle(7, 1, 0, 1, 2'd0, 4'd0);
        add_idle(1, 0, 0, 0, 2'd0, 4'd0);

        // 2: three misses to sticky alarm, clr recovers.
        add_entry(4'b0000, 2'd0);
        add_idle(1, 0, 0, 0, 2'd1, 4'd0);
        add_entry(4'b1111, 2'd1);
        add(0, 1, 1, 0, 0, 0, 0, 2'd2, 4'd0);
        add_entry(4'b0011, 2'd2);
        add_idle(1, 0, 1, 1, 2'd3, 4'd0);
        add(0, 1, 1, 0, 0, 1, 1, 2'd3, 4'd0);
        add(0, 1, 0, 0, 0, 1, 1, 2'd3, 4'd0);
        add_idle(2, 0, 1, 1, 2'd3, 4'd0);
        add(0, 0, 0, 1, 0, 0, 0, 2'd0, 4'd0);
        add(0, 0, 0, 1, 0, 0, 0, 2'd0, 4'd0);

        // 3: miss then hit clears fail_cnt; strobe in OPEN ignored.
        add_entry(4'b0000, 2'd0);
        add_idle(1, 0, 0, 0, 2'd1, 4'd0);
        add_entry(4'b1011, 2'd1);
        add_idle(1, 1, 0, 1, 2'd0, 4'd0);
        add(0, 1, 0, 0, 1, 0, 1, 2'd0, 4'd0);
        add_idle(6, 1, 0, 1, 2'd0, 4'd0);
        add_idle(1, 0, 0, 0, 2'd0, 4'd0);

        // 4: abort with clr+strobe keeps fail_cnt; clr in OPEN; clr in CHECK has no effect.
        add_entry(4'b0000, 2'd0);
        add_idle(1, 0, 0, 0, 2'd1, 4'd0);
        add(0, 1, 1, 0, 0, 0, 1, 2'd1, 4'd1);
        add(0, 1, 0, 0, 0, 0, 1, 2'd1, 4'd2);
        add(0, 1, 1, 1, 0, 0, 0, 2'd1, 4'd0);
        add_entry(4'b1011, 2'd1);
        add_idle(2, 1, 0, 1, 2'd0, 4'd0);
        add(0, 0, 0, 1, 0, 0, 0, 2'd0, 4'd0);
        add_entry(4'b1011, 2'd0);
        add(0, 0, 0, 1, 1, 0, 1, 2'd0, 4'd0);
        add(0, 0, 0, 1, 0, 0, 0, 2'd0, 4'd0);

        // 5: MR during OPEN cycle 3 and during ENTER after two bits.
        add_entry(4'b1011, 2'd0);
        add_idle(3, 1, 0, 1, 2'd0, 4'd0);
        add(1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0);
        add_entry(4'b0000, 2'd0);
        add_idle(1, 0, 0, 0, 2'd1, 4'd0);
        add(0, 1, 1, 0, 0, 0, 1, 2'd1, 4'd1);
        add(0, 1, 0, 0, 0, 0, 1, 2'd1, 4'd2);
        add(1, 1, 1, 0, 0, 0, 0, 2'd0, 4'd0);
        add_idle(1, 0, 0, 0, 2'd0, 4'd0);

        for (int i = 0; i < vec_q.size(); i++) begin
            drive_check(vec_q[i].mr, vec_q[i].vld, vec_q[i].b, vec_q[i].clr,
                        vec_q[i].exp, $sformatf("vec%0d", i));
        end

        // 6: two bits then 16 idle cycles; aborts only when the timeout is built in.
        drive_check(0, 1, 1, 0, {3'b001, 2'd0, 4'd1}, "to_bit1");
        drive_check(0, 1, 0, 0, {3'b001, 2'd0, 4'd2}, "to_bit2");
        for (int i = 1; i <= 15; i++) begin
            drive_check(0, 0, 0, 0, {3'b001, 2'd0, 4'd2}, $sformatf("to_wait%0d", i));
        end
        drive_check(0, 0, 0, 0, TO_EN ? {3'b000, 2'd1, 4'd0} : {3'b001, 2'd0, 4'd2}, "to_expire");
        drive_check(0, 0, 0, 0, TO_EN ? {3'b000, 2'd1, 4'd0} : {3'b001, 2'd0, 4'd2}, "to_after");
        drive_check(0, 0, 0, 1, TO_EN ? {3'b000, 2'd1, 4'd0} : {3'b000, 2'd0, 4'd0}, "to_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
